ethpipe_slot_ctrl: RTL
======================

Name: ethpipe_slot_ctrl

Overview:
Parametrised host-side slot controller for the ethpipe RX path. It serves NPORTS ethernet ports, each with a ring of NSLOTS RX slots in dual-port slot RAMs. It decodes the PCIe slave bus into a BAR0 register file (control, global timestamp snapshot, per-port slot status/length/drop counters) and a BAR2 slot-RAM window. It tracks the EMPTY/READY ownership of each slot and raises an interrupt. It sits between pcie_tlp's slave bus and the per-port ethpipe RX writers and slot RAMs. The RX-side done/drop pulses arrive already synchronised into clk_125.

Parameters:
NPORTS, 2, number of ethernet ports (1..4)
NSLOTS, 4, RX slots per port (2..8, need not be a power of 2)
LEN_W, 12, frame length field width in bytes
RAM_AW, 13, word-address width of one port's slot-RAM window
PORT_LSB, 14, lowest slv_adr_i bit of the BAR2 port selector
BAR_REG, 0, BAR index of the register file
BAR_RAM, 2, BAR index of the slot-RAM window

Ports:
clk_125  in  1  system/PCIe clock
sys_rst_n  in  1  reset (see Behaviour)
slv_bar_i  in  7  BAR hit vector
slv_ce_i  in  1  slave access strobe
slv_we_i  in  1  write (1) / read (0)
slv_adr_i  in  19 ([19:1])  word address
slv_dat_i  in  16  write data
slv_sel_i  in  2  byte enables
slv_dat_o  out  16  read data
ram_ce_o  out  NPORTS  slot-RAM port-A clock enable, one per port
ram_dat_i  in  16*NPORTS  slot-RAM port-A read data
eth_done_i  in  NPORTS  1-cycle pulse: the port finished a frame into its fill slot
eth_len_i  in  LEN_W*NPORTS  frame length, valid with eth_done_i
eth_drop_i  in  NPORTS  1-cycle pulse: the port dropped a frame (no free slot)
eth_fill_slot_o  out  3*NPORTS  slot index the port writes into next
eth_fill_ok_o  out  NPORTS  the fill slot is EMPTY and may be written
irq_o  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, clk_125. sys_rst_n is asynchronous and active-low.
- Reset state: all slots EMPTY; fill_ptr = rd_ptr = 0; counters 0; irq_en = 0; slv_dat_o = 0; irq_o = 0; eth_fill_ok_o = all 1; ram_ce_o = 0.
- Global counter: 64-bit, increments every cycle and wraps. A write of CTRL bit0 = 1 makes it read 0 on the next cycle. CTRL bit0 reads back 0.
- Read latency: exactly 1 cycle for BAR0 and BAR2. The read-data mux selects from bar/port values registered in the ce cycle. slv_dat_o is 0 when the previous cycle had no read hit.
- Byte enables: BAR0 writes apply only when slv_sel_i[0] = 1 (low byte).
- BAR0 word map (slv_adr_i[7:1]):
  - 0x00 CTRL: bit0 counter reset (W, self-clearing), bit1 irq_en (RW).
  - 0x01 READY summary (RO): bit p = port p has at least one READY slot.
  - 0x02..0x05 TS0..TS3: a read of TS0 latches the whole 64-bit counter into a snapshot and returns bits [15:0]. TS1..TS3 return snapshot bits [31:16], [47:32], [63:48].
  - 0x10+8p+0 READY mask (bit s = slot s READY). Writing 1 to a bit (W1C) releases that slot to EMPTY. Writing 1 to an EMPTY slot has no effect.
  - 0x10+8p+1 rd_ptr (RO).
  - 0x10+8p+2 length of slot rd_ptr (RO, zero-extended).
  - 0x10+8p+3 drop counter (16-bit, saturates at 0xFFFF; any write clears it).
  - Unmapped addresses read 0; writes to them are ignored.
- Per-port ring:
  - eth_done_i with slot[fill_ptr] EMPTY: slot becomes READY, length is stored, fill_ptr advances modulo NSLOTS.
  - eth_done_i with slot[fill_ptr] READY (protocol error): slot unchanged, drop counter increments.
  - eth_drop_i: drop counter increments. If done-error and drop occur in the same cycle, the counter increments by 2, saturating.
  - rd_ptr advances by one per cycle while slot[rd_ptr] is EMPTY and rd_ptr != fill_ptr.
  - Full ring (all slots READY): rd_ptr == fill_ptr and eth_fill_ok_o = 0.
- Simultaneous events:
  - done and W1C on the same slot in one cycle: done wins, slot is READY.
  - W1C on other slots in the same cycle is applied normally.
- eth_fill_slot_o and eth_fill_ok_o are registered and reflect state after the current cycle's updates.
- BAR2 window: port = slv_adr_i[PORT_LSB +: ceil(log2 NPORTS)]. ram_ce_o[p] = slv_ce_i & slv_bar_i[BAR_RAM] & (port == p), combinational. A port index >= NPORTS enables no RAM and reads 0.
- irq_o: registered, equal to irq_en & |READY summary.

Decomposition:
- Package ethpipe_pkg holds:
  - slot-state encoding (EMPTY = 0, READY = 1);
  - BAR0 register offsets (CTRL, RDY, TS0..TS3, PORT_BASE = 0x10, PORT_STRIDE = 8);
  - a clog2 function.
- One sub-module, ethpipe_slot_ring: per-port slot state, pointers, lengths and drop counter. It is instantiated NPORTS times via generate.

Test Plan:
- Reset, then read 0x00, 0x01 and 0x10..0x13 -> all 0x0000; eth_fill_ok_o = all 1; eth_fill_slot_o = 0.
- Port0 eth_done_i with len 0x05C -> read 0x10 = 0x0001, 0x12 = 0x005C, eth_fill_slot_o[0] = 1. W1C 0x0001 -> mask 0, rd_ptr = 1 within 2 cycles.
- NSLOTS = 4: five done pulses on port1 -> mask 0x000F, fill_ok[1] = 0, drop counter (0x1B) = 1. Release slot 0 -> fill_ok[1] = 1 and fill_slot = 0 (wrap).
- Same-cycle done on slot 2 and W1C 0x0004 -> slot 2 READY. 65540 eth_drop_i pulses -> counter = 0xFFFF; write -> 0.
- Write CTRL 0x0001 and wait 0x1234 cycles, read TS0, then TS1 -> values consistent with a single snapshot taken at the TS0 read, TS1 = 0.
- irq_en = 1, done on port0 -> irq_o = 1 within 2 cycles; release the slot -> irq_o = 0. BAR2 read at port1 address -> ram_ce_o = 2'b10 and slv_dat_o = ram_dat_i[31:16] one cycle later.

Source files
------------

// File: rtl/ethpipe_pkg.sv
// ethpipe_pkg: slot encoding, BAR0 map and helpers
// shared by the ethpipe RX slot controller.
package ethpipe_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_READY = 1'b1
  } slot_e;

  localparam logic [6:0] REG_CTRL  = 7'h00;
  localparam logic [6:0] REG_RDY   = 7'h01;
  localparam logic [6:0] REG_TS0   = 7'h02;
  localparam logic [6:0] REG_TS1   = 7'h03;
  localparam logic [6:0] REG_TS2   = 7'h04;
  localparam logic [6:0] REG_TS3   = 7'h05;
  localparam logic [6:0] PORT_BASE = 7'h10;
  localparam int PORT_STRIDE = 8;

  localparam int F_MASK  = 0;
  localparam int F_RDPTR = 1;
  localparam int F_LEN   = 2;
  localparam int F_DROP  = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic logic [6:0] port_reg(
    input int p,
    input int f
  );
    return 7'(int'(PORT_BASE) + PORT_STRIDE * p + f);
  endfunction

endpackage

// File: rtl/ethpipe_slot_ring.sv
// ethpipe_slot_ring: one port's RX slot ring with
// ownership bits, fill/read pointers, lengths, drops.
module ethpipe_slot_ring
  import ethpipe_pkg::*;
#(
  parameter int NSLOTS = 4,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done,
  input  logic [LEN_W-1:0]  len,
  input  logic              drop,
  input  logic [NSLOTS-1:0] w1c,
  input  logic              drop_clr,
  output logic [NSLOTS-1:0] rdy_mask,
  output logic [2:0]        rd_ptr,
  output logic [LEN_W-1:0]  rd_len,
  output logic [15:0]       drop_cnt,
  output logic [2:0]        fill_slot,
  output logic              fill_ok
);

  logic [NSLOTS-1:0] ready, ready_nxt;
  logic [2:0]        fill_ptr, fill_nxt;
  logic [2:0]        rd_q, rd_nxt;
  logic [LEN_W-1:0]  lens [NSLOTS];
  logic [15:0]       cnt, cnt_nxt;
  logic [16:0]       cnt_sum;
  logic              ok_q, ok_nxt;
  logic              fill_rdy, rd_rdy;
  logic              done_ok, done_err;

  function automatic logic [2:0] inc(input logic [2:0] v);
    return (v == 3'(NSLOTS - 1)) ? 3'd0 : v + 3'd1;
  endfunction

  // next ring state; a done on the fill slot overrides a release
  always_comb begin
    fill_rdy = 1'b0;
    rd_rdy   = 1'b0;
    rd_len   = '0;
    for (int s = 0; s < NSLOTS; s++) begin
      if (fill_ptr == 3'(s)) fill_rdy = (ready[s] == SLOT_READY);
      if (rd_q == 3'(s)) begin
        rd_rdy = (ready[s] == SLOT_READY);
        rd_len = lens[s];
      end
    end
    done_ok   = done & ~fill_rdy;
    done_err  = done & fill_rdy;
    fill_nxt  = done_ok ? inc(fill_ptr) : fill_ptr;
    ready_nxt = ready & ~w1c;
    for (int s = 0; s < NSLOTS; s++)
      if (done && fill_ptr == 3'(s)) ready_nxt[s] = SLOT_READY;
    ok_nxt = 1'b1;
    for (int s = 0; s < NSLOTS; s++)
      if (fill_nxt == 3'(s)) ok_nxt = ~ready_nxt[s];
    rd_nxt = (!rd_rdy && rd_q != fill_ptr) ? inc(rd_q) : rd_q;
    cnt_sum = {1'b0, cnt} + 17'(done_err) + 17'(drop);
    cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // ring registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= '0;
      fill_ptr <= '0;
      rd_q     <= '0;
      ok_q     <= 1'b1;
      cnt      <= '0;
      for (int s = 0; s < NSLOTS; s++) lens[s] <= '0;
    end else begin
      ready    <= ready_nxt;
      fill_ptr <= fill_nxt;
      rd_q     <= rd_nxt;
      ok_q     <= ok_nxt;
      cnt      <= drop_clr ? 16'd0 : cnt_nxt;
      for (int s = 0; s < NSLOTS; s++)
        if (done_ok && fill_ptr == 3'(s)) lens[s] <= len;
    end
  end

  assign rdy_mask  = ready;
  assign rd_ptr    = rd_q;
  assign drop_cnt  = cnt;
  assign fill_slot = fill_ptr;
  assign fill_ok   = ok_q;

endmodule

// File: rtl/ethpipe_slot_ctrl.sv
// ethpipe_slot_ctrl: BAR0 register file, BAR2 slot-RAM
// window and per-port RX slot rings with interrupt.
module ethpipe_slot_ctrl
  import ethpipe_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int NSLOTS   = 4,
  parameter int LEN_W    = 12,
  parameter int RAM_AW   = 13,
  parameter int PORT_LSB = 14,
  parameter int BAR_REG  = 0,
  parameter int BAR_RAM  = 2
) (
  input  logic                    clk_125,
  input  logic                    sys_rst_n,
  input  logic [6:0]              slv_bar_i,
  input  logic                    slv_ce_i,
  input  logic                    slv_we_i,
  input  logic [19:1]             slv_adr_i,
  input  logic [15:0]             slv_dat_i,
  input  logic [1:0]              slv_sel_i,
  output logic [15:0]             slv_dat_o,
  output logic [NPORTS-1:0]       ram_ce_o,
  input  logic [16*NPORTS-1:0]    ram_dat_i,
  input  logic [NPORTS-1:0]       eth_done_i,
  input  logic [LEN_W*NPORTS-1:0] eth_len_i,
  input  logic [NPORTS-1:0]       eth_drop_i,
  output logic [3*NPORTS-1:0]     eth_fill_slot_o,
  output logic [NPORTS-1:0]       eth_fill_ok_o,
  output logic                    irq_o
);

  localparam int PW = (clog2(NPORTS) < 1) ? 1 : clog2(NPORTS);

  logic [6:0]        adr;
  logic [PW-1:0]     port;
  logic              reg_hit, reg_wr, reg_rd;
  logic [NSLOTS-1:0] w1c [NPORTS];
  logic [NPORTS-1:0] drop_clr, rdy_sum;
  logic [NSLOTS-1:0] rdy_mask [NPORTS];
  logic [2:0]        rd_ptr [NPORTS];
  logic [LEN_W-1:0]  rd_len [NPORTS];
  logic [15:0]       drop_cnt [NPORTS];
  logic [63:0]       cnt, snap;
  logic              irq_en, irq_q;
  logic [15:0]       rd_val, reg_dat_q, ram_val;
  logic              reg_rd_q;
  logic [NPORTS-1:0] ram_rd_q;
  logic              unused_bits;

  assign adr     = slv_adr_i[7:1];
  assign port    = slv_adr_i[PORT_LSB +: PW];
  assign reg_hit = slv_ce_i & slv_bar_i[BAR_REG];
  assign reg_wr  = reg_hit & slv_we_i & slv_sel_i[0];
  assign reg_rd  = reg_hit & ~slv_we_i;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign w1c[p] = (reg_wr && adr == port_reg(p, F_MASK)) ?
                    slv_dat_i[NSLOTS-1:0] : '0;
    assign drop_clr[p] = reg_wr && adr == port_reg(p, F_DROP);
    assign ram_ce_o[p] = slv_ce_i & slv_bar_i[BAR_RAM] &
                         (port == PW'(p));
    assign rdy_sum[p]  = |rdy_mask[p];

    ethpipe_slot_ring #(
      .NSLOTS (NSLOTS),
      .LEN_W  (LEN_W)
    ) u_ring (
      .clk       (clk_125),
      .rst_n     (sys_rst_n),
      .done      (eth_done_i[p]),
      .len       (eth_len_i[p*LEN_W +: LEN_W]),
      .drop      (eth_drop_i[p]),
      .w1c       (w1c[p]),
      .drop_clr  (drop_clr[p]),
      .rdy_mask  (rdy_mask[p]),
      .rd_ptr    (rd_ptr[p]),
      .rd_len    (rd_len[p]),
      .drop_cnt  (drop_cnt[p]),
      .fill_slot (eth_fill_slot_o[3*p +: 3]),
      .fill_ok   (eth_fill_ok_o[p])
    );
  end

  // BAR0 read mux, sampled into reg_dat_q in the access cycle
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      adr == REG_CTRL: rd_val = {14'd0, irq_en, 1'b0};
      adr == REG_RDY:  rd_val = 16'(rdy_sum);
      adr == REG_TS0:  rd_val = cnt[15:0];
      adr == REG_TS1:  rd_val = snap[31:16];
      adr == REG_TS2:  rd_val = snap[47:32];
      adr == REG_TS3:  rd_val = snap[63:48];
      default: ;
    endcase
    for (int p = 0; p < NPORTS; p++) begin
      unique case (1'b1)
        adr == port_reg(p, F_MASK):  rd_val = 16'(rdy_mask[p]);
        adr == port_reg(p, F_RDPTR): rd_val = 16'(rd_ptr[p]);
        adr == port_reg(p, F_LEN):   rd_val = 16'(rd_len[p]);
        adr == port_reg(p, F_DROP):  rd_val = drop_cnt[p];
        default: ;
      endcase
    end
  end

  // slot RAM data arrives one cycle after ram_ce_o
  always_comb begin
    ram_val = '0;
    for (int p = 0; p < NPORTS; p++)
      if (ram_rd_q[p]) ram_val = ram_dat_i[16*p +: 16];
  end

  assign slv_dat_o = reg_rd_q ? reg_dat_q : ram_val;
  assign irq_o     = irq_q;

  // counter, snapshot, control and read-pipeline registers
  always_ff @(posedge clk_125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt       <= '0;
      snap      <= '0;
      irq_en    <= 1'b0;
      irq_q     <= 1'b0;
      reg_rd_q  <= 1'b0;
      reg_dat_q <= '0;
      ram_rd_q  <= '0;
    end else begin
      if (reg_wr && adr == REG_CTRL && slv_dat_i[0]) cnt <= '0;
      else cnt <= cnt + 64'd1;
      if (reg_wr && adr == REG_CTRL) irq_en <= slv_dat_i[1];
      if (reg_rd && adr == REG_TS0) snap <= cnt;
      irq_q     <= irq_en & |rdy_sum;
      reg_rd_q  <= reg_rd;
      reg_dat_q <= reg_rd ? rd_val : 16'd0;
      ram_rd_q  <= ram_ce_o & {NPORTS{~slv_we_i}};
    end
  end

  assign unused_bits = ^{slv_bar_i, slv_adr_i, slv_dat_i,
                         slv_sel_i, 32'(RAM_AW)};

endmodule
